// File: rtl/memory_access_cycle_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
interface memory_access_cycle_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport master (
    output mem_read, mem_write, mem_address, mem_writedata, mem_byteen,
    input  mem_readdata, mem_busywait
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata, mem_byteen,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/memory_access_cycle.sv
// Memory stage of the RV32 pipeline: EX/MEM register, data-memory handshake,
// store lane steering, load extraction and the MEM/WB register.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort accesses that stay
// busy for 255 WAIT cycles (MemErrW pulse); otherwise WAIT is unbounded.
//
// state  | meaning
// S_RUN  | new op in EX/MEM; issue the access, complete if memory is ready
// S_WAIT | memory busy; request held stable until busywait drops
module memory_access_cycle (
  input  logic                          CLK,
  input  logic                          RESETn,
  input  logic [31:0]                   ALUOutM,
  input  logic [31:0]                   StoreCounterOutM,
  input  logic [5:0]                    ALUSelectM,
  input  logic [4:0]                    WriteAddressM,
  input  logic                          RegWriteM,
  input  logic                          MemReadM,
  input  logic                          MemWriteM,
  output logic                          StallM,
  memory_access_cycle_if.master         mem,
  output logic [31:0]                   ReadDataW,
  output logic [31:0]                   ALUOutW,
  output logic [4:0]                    WriteAddressW,
  output logic                          RegWriteW,
  output logic                          MemReadW,
  output logic                          MisalignW,
  output logic                          MemErrW
);

  typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  // Only funct3 matters in this stage; the upper select bits belong to execute.
  logic unused_sel;
  assign unused_sel = ^ALUSelectM[5:3];

  state_t      state_q, state_d;

  logic [31:0] ex_alu_q, ex_alu_d;
  logic [31:0] ex_data_q, ex_data_d;
  logic [2:0]  ex_f3_q, ex_f3_d;
  logic [4:0]  ex_wa_q, ex_wa_d;
  logic        ex_rw_q, ex_rw_d;
  logic        ex_mr_q, ex_mr_d;
  logic        ex_mw_q, ex_mw_d;

  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [4:0]  wb_wa_q, wb_wa_d;
  logic        wb_rw_q, wb_rw_d;
  logic        wb_mr_q, wb_mr_d;
  logic        wb_mis_q, wb_mis_d;

  logic [1:0]  lane;
  logic        aligned, access, misalign, stall, timeout_hit;
  logic        rd_o, wr_o;
  logic [31:0] wdata_o, shifted, load_data;
  logic [3:0]  be_o;

  assign lane = ex_alu_q[1:0];

  // Alignment decode from the latched op: halfwords need bit 0 clear, words need both.
  always_comb begin
    aligned = 1'b1;
    if (ex_f3_q[1:0] == 2'b01 && lane[0])        aligned = 1'b0;
    if (ex_f3_q[1:0] == 2'b10 && lane != 2'b00)  aligned = 1'b0;
    access   = (ex_mr_q | ex_mw_q) & aligned;
    misalign = (ex_mr_q | ex_mw_q) & ~aligned;
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       mem_err_q, mem_err_d;

  assign timeout_hit = (state_q == S_WAIT) && (tmo_cnt_q == 8'hFF) && mem.mem_busywait;

  // Busy-cycle counter: counts while waiting, cleared whenever the FSM is in RUN.
  always_comb begin
    tmo_cnt_d = (state_q == S_WAIT) ? tmo_cnt_q + 8'd1 : 8'd0;
    mem_err_d = timeout_hit;
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      tmo_cnt_q <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign MemErrW = mem_err_q;
`else
  assign timeout_hit = 1'b0;
  assign MemErrW     = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= S_RUN;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (access && mem.mem_busywait && !timeout_hit) state_d = S_WAIT;
      S_WAIT:  if (!mem.mem_busywait || timeout_hit)          state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // FSM outputs: stall, request strobes and store lane steering.
  always_comb begin
    stall   = access & mem.mem_busywait & ~timeout_hit;
    rd_o    = access & ex_mr_q;
    wr_o    = access & ex_mw_q & ~ex_mr_q;
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    if (wr_o) begin
      case (ex_f3_q[1:0])
        2'b00: begin
          be_o    = 4'b0001 << lane;
          wdata_o = {24'h0, ex_data_q[7:0]} << {lane, 3'b000};
        end
        2'b01: begin
          be_o    = 4'b0011 << {lane[1], 1'b0};
          wdata_o = {16'h0, ex_data_q[15:0]} << {lane[1], 4'b0000};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = ex_data_q;
        end
      endcase
    end
  end

  assign StallM            = stall;
  assign mem.mem_read      = rd_o;
  assign mem.mem_write     = wr_o;
  assign mem.mem_address   = {ex_alu_q[31:2], 2'b00};
  assign mem.mem_writedata = wdata_o;
  assign mem.mem_byteen    = be_o;

  // Load extraction: bring the addressed lane down, then extend per funct3.
  always_comb begin
    shifted = mem.mem_readdata >> {lane, 3'b000};
    case (ex_f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // EX/MEM next value: load on every unstalled edge, hold while stalled.
  always_comb begin
    ex_alu_d  = ex_alu_q;
    ex_data_d = ex_data_q;
    ex_f3_d   = ex_f3_q;
    ex_wa_d   = ex_wa_q;
    ex_rw_d   = ex_rw_q;
    ex_mr_d   = ex_mr_q;
    ex_mw_d   = ex_mw_q;
    if (!stall) begin
      ex_alu_d  = ALUOutM;
      ex_data_d = StoreCounterOutM;
      ex_f3_d   = ALUSelectM[2:0];
      ex_wa_d   = WriteAddressM;
      ex_rw_d   = RegWriteM;
      ex_mr_d   = MemReadM;
      ex_mw_d   = MemWriteM;
    end
  end

  // MEM/WB next value: completion writes back, faulted ops and stalls become bubbles.
  always_comb begin
    wb_rdata_d = wb_rdata_q;
    wb_alu_d   = wb_alu_q;
    wb_wa_d    = wb_wa_q;
    wb_rw_d    = 1'b0;
    wb_mr_d    = 1'b0;
    wb_mis_d   = 1'b0;
    if (!stall) begin
      wb_rdata_d = load_data;
      wb_alu_d   = ex_alu_q;
      wb_wa_d    = ex_wa_q;
      wb_rw_d    = ex_rw_q & ~misalign & ~timeout_hit;
      wb_mr_d    = ex_mr_q & ~misalign & ~timeout_hit;
      wb_mis_d   = misalign;
    end
  end

  // Pipeline registers; reset leaves both stages holding a bubble.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ex_alu_q   <= 32'h0;
      ex_data_q  <= 32'h0;
      ex_f3_q    <= 3'b000;
      ex_wa_q    <= 5'd0;
      ex_rw_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      ex_mw_q    <= 1'b0;
      wb_rdata_q <= 32'h0;
      wb_alu_q   <= 32'h0;
      wb_wa_q    <= 5'd0;
      wb_rw_q    <= 1'b0;
      wb_mr_q    <= 1'b0;
      wb_mis_q   <= 1'b0;
    end else begin
      ex_alu_q   <= ex_alu_d;
      ex_data_q  <= ex_data_d;
      ex_f3_q    <= ex_f3_d;
      ex_wa_q    <= ex_wa_d;
      ex_rw_q    <= ex_rw_d;
      ex_mr_q    <= ex_mr_d;
      ex_mw_q    <= ex_mw_d;
      wb_rdata_q <= wb_rdata_d;
      wb_alu_q   <= wb_alu_d;
      wb_wa_q    <= wb_wa_d;
      wb_rw_q    <= wb_rw_d;
      wb_mr_q    <= wb_mr_d;
      wb_mis_q   <= wb_mis_d;
    end
  end

  assign ReadDataW     = wb_rdata_q;
  assign ALUOutW       = wb_alu_q;
  assign WriteAddressW = wb_wa_q;
  assign RegWriteW     = wb_rw_q;
  assign MemReadW      = wb_mr_q;
  assign MisalignW     = wb_mis_q;

endmodule

// File: tb/tb_memory_access_cycle.sv
// Scoreboard bench: stimulus pushes expected memory requests and writebacks,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_memory_access_cycle;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [31:0] ALUOutM = '0, StoreCounterOutM = '0;
  logic [5:0]  ALUSelectM = '0;
  logic [4:0]  WriteAddressM = '0;
  logic        RegWriteM = 1'b0, MemReadM = 1'b0, MemWriteM = 1'b0;
  logic        StallM;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteAddressW;
  logic        RegWriteW, MemReadW, MisalignW, MemErrW;

  memory_access_cycle_if mem_bus ();

  memory_access_cycle dut (
    .CLK(CLK), .RESETn(RESETn),
    .ALUOutM(ALUOutM), .StoreCounterOutM(StoreCounterOutM), .ALUSelectM(ALUSelectM),
    .WriteAddressM(WriteAddressM), .RegWriteM(RegWriteM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .StallM(StallM), .mem(mem_bus),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteAddressW(WriteAddressW),
    .RegWriteW(RegWriteW), .MemReadW(MemReadW), .MisalignW(MisalignW), .MemErrW(MemErrW)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct packed {
    logic        rw;
    logic        mr;
    logic        mis;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wa;
    logic        chk_rd;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: accepted memory requests and visible writebacks.
  always @(negedge CLK) begin
    if (RESETn) begin
      if ((mem_bus.mem_read || mem_bus.mem_write) && !mem_bus.mem_busywait) begin
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_unexpected actual=rd%0b wr%0b addr=%h required=none",
                   mem_bus.mem_read, mem_bus.mem_write, mem_bus.mem_address);
        end else begin
          req_t e;
          e = req_q.pop_front();
          chk("req_strobes", {30'h0, mem_bus.mem_read, mem_bus.mem_write}, {30'h0, e.rd, e.wr});
          chk("req_addr", mem_bus.mem_address, e.addr);
          chk("req_wdata", mem_bus.mem_writedata, e.wdata);
          chk("req_byteen", {28'h0, mem_bus.mem_byteen}, {28'h0, e.be});
        end
      end
      if (RegWriteW || MemReadW || MisalignW || MemErrW) begin
        if (wb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected actual=rw%0b mr%0b mis%0b err%0b alu=%h required=none",
                   RegWriteW, MemReadW, MisalignW, MemErrW, ALUOutW);
        end else begin
          wb_t w;
          w = wb_q.pop_front();
          chk("wb_flags", {28'h0, RegWriteW, MemReadW, MisalignW, MemErrW},
              {28'h0, w.rw, w.mr, w.mis, w.err});
          chk("wb_alu", ALUOutW, w.alu);
          chk("wb_wa", {27'h0, WriteAddressW}, {27'h0, w.wa});
          if (w.chk_rd) chk("wb_rdata", ReadDataW, w.rdata);
        end
      end
    end
  end

  task automatic bubble();
    ALUOutM = '0; StoreCounterOutM = '0; ALUSelectM = '0; WriteAddressM = '0;
    RegWriteM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  // Issue one op (called just after a rising edge) and serve it with nwait busy cycles.
  task automatic do_op(input logic [31:0] alu, input logic [31:0] data, input logic [2:0] f3,
                       input logic [4:0] wa, input logic rw, input logic mr, input logic mw,
                       input logic [31:0] rdata, input int nwait,
                       input logic [31:0] exp_wd, input logic [3:0] exp_be,
                       input logic [31:0] exp_rd, input logic exp_mis, input logic chk_rd);
    ALUOutM = alu; StoreCounterOutM = data; ALUSelectM = {3'b000, f3};
    WriteAddressM = wa; RegWriteM = rw; MemReadM = mr; MemWriteM = mw;
    if ((mr || mw) && !exp_mis)
      req_q.push_back('{rd: mr, wr: mw, addr: {alu[31:2], 2'b00}, wdata: exp_wd, be: exp_be});
    if ((rw && !exp_mis) || exp_mis)
      wb_q.push_back('{rw: rw && !exp_mis, mr: mr && !exp_mis, mis: exp_mis, err: 1'b0,
                       rdata: exp_rd, alu: alu, wa: wa, chk_rd: chk_rd});
    @(posedge CLK); #1;
    bubble();
    mem_bus.mem_readdata = rdata;
    mem_bus.mem_busywait = (nwait > 0);
    for (int i = 0; i < nwait; i++) begin
      @(negedge CLK);
      chk("stall_hi", {31'h0, StallM}, 32'h1);
      chk("hold_addr", mem_bus.mem_address, {alu[31:2], 2'b00});
      chk("hold_strobes", {30'h0, mem_bus.mem_read, mem_bus.mem_write}, {30'h0, mr, mw});
      chk("hold_rw_bubble", {31'h0, RegWriteW}, 32'h0);
      @(posedge CLK); #1;
    end
    mem_bus.mem_busywait = 1'b0;
    @(negedge CLK);
    chk("stall_lo", {31'h0, StallM}, 32'h0);
    @(posedge CLK); #1;
  endtask

  initial begin
    mem_bus.mem_readdata = '0;
    mem_bus.mem_busywait = 1'b0;
    #12;
    chk("rst_stall", {31'h0, StallM}, 32'h0);
    chk("rst_strobes", {30'h0, mem_bus.mem_read, mem_bus.mem_write}, 32'h0);
    chk("rst_wbflags", {27'h0, RegWriteW, MemReadW, MisalignW, MemErrW, 1'b0}, 32'h0);
    chk("rst_rdata", ReadDataW, 32'h0);
    chk("rst_alu", ALUOutW, 32'h0);
    chk("rst_byteen", {28'h0, mem_bus.mem_byteen}, 32'h0);
    @(posedge CLK); #1;
    RESETn = 1'b1;

    //     alu           data          f3     wa  rw mr mw rdata        wait exp_wd        be       exp_rd        mis chk
    do_op(32'h0000_0100, 32'h0,        3'b010, 5,  1, 1, 0, 32'hDEADBEEF, 0, 32'h0,        4'b0000, 32'hDEADBEEF, 0, 1); // LW
    do_op(32'h0000_0103, 32'h0,        3'b000, 6,  1, 1, 0, 32'h80FF1234, 0, 32'h0,        4'b0000, 32'hFFFFFF80, 0, 1); // LB
    do_op(32'h0000_0103, 32'h0,        3'b100, 6,  1, 1, 0, 32'h80FF1234, 0, 32'h0,        4'b0000, 32'h00000080, 0, 1); // LBU
    do_op(32'h0000_0202, 32'h0000ABCD, 3'b001, 0,  0, 0, 1, 32'h0,        3, 32'hABCD0000, 4'b1100, 32'h0,        0, 0); // SH
    do_op(32'h0000_0101, 32'h0,        3'b010, 8,  1, 1, 0, 32'h11223344, 0, 32'h0,        4'b0000, 32'h0,        1, 0); // LW misaligned
    do_op(32'h0000_0201, 32'h00000055, 3'b000, 0,  0, 0, 1, 32'h0,        1, 32'h00005500, 4'b0010, 32'h0,        0, 0); // SB
    do_op(32'h0000_0102, 32'h0,        3'b001, 10, 1, 1, 0, 32'h80017FFF, 2, 32'h0,        4'b0000, 32'hFFFF8001, 0, 1); // LH
    do_op(32'h0000_0102, 32'h0,        3'b101, 11, 1, 1, 0, 32'h80017FFF, 0, 32'h0,        4'b0000, 32'h00008001, 0, 1); // LHU
    do_op(32'h0000_0304, 32'hCAFEF00D, 3'b010, 0,  0, 0, 1, 32'h0,        0, 32'hCAFEF00D, 4'b1111, 32'h0,        0, 0); // SW
    do_op(32'h1234_5678, 32'h0,        3'b000, 7,  1, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        0, 0); // ALU op
    do_op(32'h0000_0203, 32'h00001111, 3'b001, 0,  0, 0, 1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        1, 0); // SH misaligned
    do_op(32'h0000_0102, 32'h0,        3'b010, 12, 1, 1, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        1, 0); // LW at 0x102
    do_op(32'h0000_0010, 32'h0,        3'b000, 13, 1, 1, 0, 32'h000000F0, 0, 32'h0,        4'b0000, 32'hFFFFFFF0, 0, 1); // LB lane 0

    // Reset in WAIT: request must fall with RESETn, writeback cleared.
    ALUOutM = 32'h400; ALUSelectM = 6'b000010; WriteAddressM = 9; RegWriteM = 1; MemReadM = 1;
    @(posedge CLK); #1;
    bubble();
    mem_bus.mem_readdata = 32'h55AA55AA;
    mem_bus.mem_busywait = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("wait_read", {31'h0, mem_bus.mem_read}, 32'h1);
    chk("wait_stall", {31'h0, StallM}, 32'h1);
    #1 RESETn = 1'b0;
    #1;
    chk("rstw_read", {31'h0, mem_bus.mem_read}, 32'h0);
    chk("rstw_stall", {31'h0, StallM}, 32'h0);
    chk("rstw_w", {ReadDataW | ALUOutW}, 32'h0);
    chk("rstw_wflags", {26'h0, WriteAddressW, RegWriteW}, 32'h0);
    mem_bus.mem_busywait = 1'b0;
    @(posedge CLK); #1;
    RESETn = 1'b1;
    do_op(32'h0000_0500, 32'h0, 3'b010, 14, 1, 1, 0, 32'h0BADF00D, 0, 32'h0, 4'b0000, 32'h0BADF00D, 0, 1);

`ifdef MEM_ACCESS_TIMEOUT_EN
    begin
      int stalls = 0;
      ALUOutM = 32'h600; ALUSelectM = 6'b000010; WriteAddressM = 15; RegWriteM = 1; MemReadM = 1;
      wb_q.push_back('{rw: 1'b0, mr: 1'b0, mis: 1'b0, err: 1'b1, rdata: 32'h0,
                       alu: 32'h600, wa: 5'd15, chk_rd: 1'b0});
      @(posedge CLK); #1;
      bubble();
      mem_bus.mem_busywait = 1'b1;
      @(negedge CLK);
      for (int i = 0; i < 400 && StallM; i++) begin
        stalls++;
        @(negedge CLK);
      end
      chk("tmo_stall_cycles", stalls, 256);
      @(posedge CLK); #1;
      mem_bus.mem_busywait = 1'b0;
      @(posedge CLK); #1;
    end
`endif

    repeat (3) @(posedge CLK);
    #1;
    chk("req_q_drained", req_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
